id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a skid entry so in_ready never depends combinationally on out_ready.
// Optional stall/bubble performance counters are enabled by defining ID_EX_STAGE_PERF_EN.
`default_nettype none

module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int WB_W  = 2,
   parameter int M_W   = 3,
   parameter int CNT_W = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WB_W-1:0] ctlwb_in,
   input  logic [M_W-1:0]  ctlm_in,
   input  logic [3:0]      ctlex_in,
   input  logic [XLEN-1:0] npc_in,
   input  logic [XLEN-1:0] rdata1_in,
   input  logic [XLEN-1:0] rdata2_in,
   input  logic [XLEN-1:0] imm_in,
   input  logic [RA_W-1:0] rt_in,
   input  logic [RA_W-1:0] rd_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WB_W-1:0] wb_ctl,
   output logic [M_W-1:0]  m_ctl,
   output logic            regdst,
   output logic            alusrc,
   output logic [1:0]      aluop,
   output logic [XLEN-1:0] npc,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   output logic [XLEN-1:0] imm,
   output logic [RA_W-1:0] rt,
   output logic [RA_W-1:0] rd
`ifdef ID_EX_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   typedef struct packed {
      logic [WB_W-1:0] wb;
      logic [M_W-1:0]  m;
      logic [3:0]      ex;
      logic [XLEN-1:0] npc;
      logic [XLEN-1:0] rdata1;
      logic [XLEN-1:0] rdata2;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rt;
      logic [RA_W-1:0] rd;
   } bundle_t;

   bundle_t main_q;
   bundle_t skid_q;
   bundle_t in_bundle;
   logic    main_valid;
   logic    skid_valid;
   logic    accept;
   logic    retire;

   assign in_bundle = '{wb: ctlwb_in, m: ctlm_in, ex: ctlex_in, npc: npc_in,
                        rdata1: rdata1_in, rdata2: rdata2_in, imm: imm_in,
                        rt: rt_in, rd: rd_in};

   assign in_ready = ~skid_valid;
   assign accept   = in_valid & in_ready;
   assign retire   = main_valid & out_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_valid && !retire) begin
         // Main is stalled: a new bundle can only park in the skid entry.
         if (accept) begin
            skid_q     <= in_bundle;
            skid_valid <= 1'b1;
         end
      end else if (skid_valid) begin
         // in_ready is low here, so no accept can collide with the skid move.
         main_q     <= skid_q;
         main_valid <= 1'b1;
         skid_valid <= 1'b0;
      end else if (accept) begin
         main_q     <= in_bundle;
         main_valid <= 1'b1;
      end else begin
         main_valid <= 1'b0;
      end
   end

   assign out_valid = main_valid;
   assign wb_ctl    = main_valid ? main_q.wb : '0;
   assign m_ctl     = main_valid ? main_q.m  : '0;
   assign regdst    = main_valid & main_q.ex[3];
   assign aluop     = main_valid ? main_q.ex[2:1] : 2'b00;
   assign alusrc    = main_valid & main_q.ex[0];
   assign npc       = main_q.npc;
   assign rdata1    = main_q.rdata1;
   assign rdata2    = main_q.rdata2;
   assign imm       = main_q.imm;
   assign rt        = main_q.rt;
   assign rd        = main_q.rd;

`ifdef ID_EX_STAGE_PERF_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         if (!main_valid && out_ready && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (skid buffering, flush, reset, optional counters).
`default_nettype none

module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int RA_W  = 5;
   localparam int WB_W  = 2;
   localparam int M_W   = 3;
`ifdef ID_EX_STAGE_PERF_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 32;
`endif

   logic            clock = 1'b0;
   logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [WB_W-1:0] ctlwb_in, wb_ctl;
   logic [M_W-1:0]  ctlm_in, m_ctl;
   logic [3:0]      ctlex_in;
   logic [XLEN-1:0] npc_in, rdata1_in, rdata2_in, imm_in;
   logic [XLEN-1:0] npc, rdata1, rdata2, imm;
   logic [RA_W-1:0] rt_in, rd_in, rt, rd;
   logic            regdst, alusrc;
   logic [1:0]      aluop;
`ifdef ID_EX_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .WB_W(WB_W), .M_W(M_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
      .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
      .rt_in(rt_in), .rd_in(rd_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc), .aluop(aluop),
      .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .imm(imm), .rt(rt), .rd(rd)
`ifdef ID_EX_STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_bundle(input logic [XLEN-1:0] n);
      npc_in    = n;
      rdata1_in = n + 32'h11;
      rdata2_in = n + 32'h22;
      imm_in    = n + 32'h33;
      rt_in     = n[RA_W-1:0] ^ 5'h0A;
      rd_in     = n[RA_W-1:0] ^ 5'h15;
      ctlwb_in  = 2'b11;
      ctlm_in   = 3'b101;
      ctlex_in  = 4'b1011;
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_bundle(32'h0);
      tick();
      reset = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_flags: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      checks++;
      if ({wb_ctl, m_ctl, regdst, aluop, alusrc} !== 9'd0 || npc !== 32'd0 || rd !== 5'd0) begin
         failures++;
         $display("FAIL reset_fields: ctl=%h npc=%h rd=%h required 0", {wb_ctl, m_ctl, regdst, aluop, alusrc}, npc, rd);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1; in_valid = 1'b1;
      set_bundle(32'h100);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || npc !== 32'h100 || regdst !== 1'b1 || aluop !== 2'b01 || alusrc !== 1'b1) begin
         failures++;
         $display("FAIL single_out: valid=%b npc=%h regdst=%b aluop=%b alusrc=%b required 1/100/1/01/1",
                  out_valid, npc, regdst, aluop, alusrc);
      end
      checks++;
      if (wb_ctl !== 2'b11 || m_ctl !== 3'b101 || rdata1 !== 32'h111 || imm !== 32'h133 || rt !== 5'h0A) begin
         failures++;
         $display("FAIL single_fields: wb=%b m=%b rdata1=%h imm=%h rt=%h required 11/101/111/133/0a",
                  wb_ctl, m_ctl, rdata1, imm, rt);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || wb_ctl !== 2'b00 || m_ctl !== 3'b000 || aluop !== 2'b00 || npc !== 32'h100) begin
         failures++;
         $display("FAIL bubble: valid=%b wb=%b m=%b aluop=%b npc=%h required 0/00/000/00/100",
                  out_valid, wb_ctl, m_ctl, aluop, npc);
      end
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] exp_npc [3];
      exp_npc[0] = 32'hA00; exp_npc[1] = 32'hB00; exp_npc[2] = 32'hC00;
      out_ready = 1'b0; in_valid = 1'b1;
      set_bundle(exp_npc[0]);
      tick();
      set_bundle(exp_npc[1]);
      tick();
      set_bundle(exp_npc[2]);
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || npc !== 32'hA00) begin
         failures++;
         $display("FAIL stream_full: in_ready=%b valid=%b npc=%h required 0/1/a00", in_ready, out_valid, npc);
      end
      // C stays on the input until it is taken; record each retired bundle in order.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || npc !== exp_npc[i]) begin
            failures++;
            $display("FAIL stream_order%0d: valid=%b npc=%h required 1/%h", i, out_valid, npc, exp_npc[i]);
         end
         if (i == 0) begin
            tick();
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL stream_ready: in_ready=%b required 1", in_ready);
            end
         end else begin
            if (i == 1) begin
               tick();
               in_valid = 1'b0;
            end else begin
               tick();
            end
         end
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_drain: valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      set_bundle(32'hD00); tick();
      set_bundle(32'hE00); tick();
      set_bundle(32'hF00); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {wb_ctl, m_ctl, regdst, aluop, alusrc} !== 9'd0) begin
         failures++;
         $display("FAIL flush: valid=%b in_ready=%b ctl=%h required 0/1/0",
                  out_valid, in_ready, {wb_ctl, m_ctl, regdst, aluop, alusrc});
      end
      out_ready = 1'b1;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_leak: valid=%b npc=%h required valid 0", out_valid, npc);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1;
      set_bundle(32'h700); tick();
      set_bundle(32'h800); tick();
      in_valid = 1'b0; reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || npc !== 32'd0 || rdata2 !== 32'd0 || imm !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid: valid=%b in_ready=%b npc=%h rdata2=%h imm=%h required 0/1/0/0/0",
                  out_valid, in_ready, npc, rdata2, imm);
      end
`ifdef ID_EX_STAGE_PERF_EN
      checks++;
      if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
         failures++;
         $display("FAIL reset_cnt: stall=%0d bubble=%0d required 0/0", stall_cnt, bubble_cnt);
      end
`endif
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_leak: valid=%b required 0", out_valid);
      end
   endtask

`ifdef ID_EX_STAGE_PERF_EN
   task automatic test_perf();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      reset = 1'b1; out_ready = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (bubble_cnt !== 4'd3 || stall_cnt !== 4'd0) begin
         failures++;
         $display("FAIL perf_bubble: bubble=%0d stall=%0d required 3/0", bubble_cnt, stall_cnt);
      end
      reset = 1'b0; out_ready = 1'b0;
      tick();
      reset = 1'b1; in_valid = 1'b1;
      set_bundle(32'h900);
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      checks++;
      if (stall_cnt !== 4'd15 || bubble_cnt !== 4'd0) begin
         failures++;
         $display("FAIL perf_stall: stall=%0d bubble=%0d required 15/0", stall_cnt, bubble_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_flush();
      test_reset_mid();
`ifdef ID_EX_STAGE_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
